// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared types and constants for the SPRAM frame buffer:
//               power-state encoding and SP256K geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    // SP256K geometry: 16K words of 16 bits, nibble write mask
    localparam int SPRAM_AW     = 14;
    localparam int SPRAM_DW     = 16;
    localparam int SPRAM_MASK_W = 4;

    // Bank power sequencing states
    typedef enum logic [1:0] {
        WAKE     = 2'd0,
        ACTIVE   = 2'd1,
        SLEEPING = 2'd2
    } pwr_state_t;

endpackage
`default_nettype wire

// File: rtl/spram_bank.sv
`default_nettype none
// ============================================================================
// Module      : spram_bank
// Description : One 16K x 16 single-port RAM bank with the SP256K pin set.
//               Standby is held off and the array is always powered; only
//               SLEEP is driven from outside. Read data is registered and
//               holds its value until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_bank
    import fb_pkg::*;
(
    input  logic                    clk,
    input  logic                    cs,
    input  logic                    we,
    input  logic [SPRAM_MASK_W-1:0] mask,
    input  logic [SPRAM_AW-1:0]     addr,
    input  logic [SPRAM_DW-1:0]     din,
    input  logic                    sleep,
    output logic [SPRAM_DW-1:0]     dout
);

    localparam int DEPTH = 1 << SPRAM_AW;
    localparam int NIB_W = SPRAM_DW / SPRAM_MASK_W;

    // Tied power pins: standby never used, power never removed
    logic w_stdby;
    logic w_pwroff_n;
    logic w_access;

    assign w_stdby    = 1'b0;
    assign w_pwroff_n = 1'b1;
    assign w_access   = cs && !sleep && !w_stdby && w_pwroff_n;

    logic [SPRAM_DW-1:0] r_mem [DEPTH];
    logic [SPRAM_DW-1:0] r_dout;

    // Array access: nibble-masked write, or registered read
    always_ff @(posedge clk) begin
        if (w_access) begin
            if (we) begin
                for (int n = 0; n < SPRAM_MASK_W; n++) begin
                    if (mask[n]) begin
                        r_mem[addr][n*NIB_W +: NIB_W] <= din[n*NIB_W +: NIB_W];
                    end
                end
            end else begin
                r_dout <= r_mem[addr];
            end
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/spram_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : spram_frame_buffer
// Description : Multi-bank SPRAM frame buffer with independent valid/ready
//               write and read ports. A write and a read proceed together
//               when they hit different banks; same-bank collisions favour
//               the read until the waiting write has been held off for
//               STARVE_LIMIT cycles. Banks are put to SLEEP on request and
//               brought back through a timed wake phase.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_frame_buffer
    import fb_pkg::*;
#(
    parameter int NUM_BANKS    = 2,
    parameter int ADDR_W       = 14 + $clog2(NUM_BANKS),
    parameter int STARVE_LIMIT = 4,
    parameter int WAKE_CYCLES  = 3
)(
    input  logic                    CK,
    input  logic                    RESET_N,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [SPRAM_DW-1:0]     wr_data,
    input  logic [SPRAM_MASK_W-1:0] wr_mask,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_data_valid,
    output logic [SPRAM_DW-1:0]     rd_data,
    input  logic                    sleep_req,
    output logic                    busy
);

    localparam int BANK_W   = (ADDR_W > SPRAM_AW) ? (ADDR_W - SPRAM_AW) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WAKE_W   = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [WAKE_W-1:0]   WAKE_LAST  = WAKE_W'(WAKE_CYCLES - 1);

    pwr_state_t r_state;
    pwr_state_t w_state_next;

    logic [WAKE_W-1:0]    r_wake_cnt;
    logic [STARVE_W-1:0]  r_starve_cnt;
    logic                 r_rd_pend;
    logic [BANK_W-1:0]    r_rd_bank;

    logic [BANK_W-1:0]    w_wr_bank;
    logic [BANK_W-1:0]    w_rd_bank;
    logic                 w_rd_oob;
    logic                 w_conflict;
    logic                 w_starved;
    logic                 w_wake_done;
    logic                 w_sleep_all;
    logic                 w_wr_fire;
    logic                 w_rd_fire;
    logic [SPRAM_DW-1:0]  w_rd_mux;

    logic [NUM_BANKS-1:0] w_bank_cs;
    logic [NUM_BANKS-1:0] w_bank_sleep;
    logic [SPRAM_DW-1:0]  w_bank_dout [NUM_BANKS];

    // Bank index is the address field above the in-bank word address
    generate
        if (ADDR_W > SPRAM_AW) begin : g_bank_field
            assign w_wr_bank = wr_addr[ADDR_W-1:SPRAM_AW];
            assign w_rd_bank = rd_addr[ADDR_W-1:SPRAM_AW];
        end else begin : g_single_bank
            assign w_wr_bank = '0;
            assign w_rd_bank = '0;
        end
    endgenerate

    // Only a bank count that is not a power of two leaves unused indices
    generate
        if ((1 << BANK_W) > NUM_BANKS) begin : g_oob_check
            assign w_rd_oob = (w_rd_bank >= BANK_W'(NUM_BANKS));
        end else begin : g_no_oob
            assign w_rd_oob = 1'b0;
        end
    endgenerate

    // Collision detect: a read into a nonexistent bank never collides
    always_comb begin
        w_conflict  = wr_valid && rd_valid && !w_rd_oob && (w_wr_bank == w_rd_bank);
        w_starved   = (r_starve_cnt == STARVE_MAX);
        w_wake_done = (r_state == WAKE) && (r_wake_cnt == WAKE_LAST);
    end

    // Power state register
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= WAKE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Power state transitions; sleep only once the read path is drained
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAKE: begin
                if (w_wake_done) begin
                    w_state_next = sleep_req ? SLEEPING : ACTIVE;
                end
            end
            ACTIVE: begin
                if (sleep_req && !r_rd_pend && !w_wr_fire && !w_rd_fire) begin
                    w_state_next = SLEEPING;
                end
            end
            SLEEPING: begin
                if (!sleep_req) begin
                    w_state_next = WAKE;
                end
            end
            default: w_state_next = WAKE;
        endcase
    end

    // Port readiness, busy flag and bank sleep derived from the power state
    always_comb begin
        wr_ready    = 1'b0;
        rd_ready    = 1'b0;
        busy        = 1'b1;
        w_sleep_all = 1'b0;
        case (r_state)
            ACTIVE: begin
                busy     = 1'b0;
                wr_ready = !w_conflict || w_starved;
                rd_ready = !w_conflict || !w_starved;
            end
            SLEEPING: begin
                w_sleep_all = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_wr_fire    = wr_valid && wr_ready;
    assign w_rd_fire    = rd_valid && rd_ready;
    assign w_bank_sleep = {NUM_BANKS{w_sleep_all}};

    // Wake timer runs only while in WAKE and restarts on every entry
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wake_cnt <= '0;
        end else if ((r_state == WAKE) && !w_wake_done) begin
            r_wake_cnt <= r_wake_cnt + WAKE_W'(1);
        end else begin
            r_wake_cnt <= '0;
        end
    end

    // Count consecutive cycles a waiting write has been refused
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_starve_cnt <= '0;
        end else if (!wr_valid || wr_ready) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    // Remember which bank an accepted read went to, for the return mux
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_pend <= 1'b0;
            r_rd_bank <= '0;
        end else begin
            r_rd_pend <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_bank <= w_rd_bank;
            end
        end
    end

    // Return mux; an index with no bank behind it reads as zero
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_rd_bank == BANK_W'(i)) begin
                w_rd_mux = w_bank_dout[i];
            end
        end
    end

    // Capture returned word and pulse valid; data holds between pulses
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_data_valid <= r_rd_pend;
            if (r_rd_pend) begin
                rd_data <= w_rd_mux;
            end
        end
    end

    // Per-bank steering: arbitration guarantees at most one port per bank
    generate
        for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
            logic w_wr_sel;
            logic w_rd_sel;

            assign w_wr_sel     = w_wr_fire && (w_wr_bank == BANK_W'(i));
            assign w_rd_sel     = w_rd_fire && (w_rd_bank == BANK_W'(i));
            assign w_bank_cs[i] = w_wr_sel || w_rd_sel;

            spram_bank u_bank (
                .clk   (CK),
                .cs    (w_bank_cs[i]),
                .we    (w_wr_sel),
                .mask  (wr_mask),
                .addr  (w_wr_sel ? wr_addr[SPRAM_AW-1:0] : rd_addr[SPRAM_AW-1:0]),
                .din   (wr_data),
                .sleep (w_bank_sleep[i]),
                .dout  (w_bank_dout[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
